// File: rtl/dt_peak_scan.sv
// Raster scan of the distance-transform result map: packed threshold mask,
// map maximum with its first address, and object-pixel count.
module dt_peak_scan #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int WORD_W = 16,
    localparam int NPIX    = IMG_W * IMG_H,
    localparam int PIX_AW  = $clog2(NPIX),
    localparam int BIT_AW  = $clog2(WORD_W),
    localparam int WORD_AW = PIX_AW - BIT_AW,
    localparam int CNT_W   = PIX_AW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         thr,
    output logic               res_rd,
    output logic [PIX_AW-1:0]  res_addr,
    input  logic [7:0]         res_di,
    output logic               msk_wr,
    output logic [WORD_AW-1:0] msk_addr,
    output logic [WORD_W-1:0]  msk_do,
    output logic [7:0]         max_val,
    output logic [PIX_AW-1:0]  max_addr,
    output logic [CNT_W-1:0]   obj_cnt,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [PIX_AW-1:0]    pix_cnt_r;
    logic [7:0]           thr_q_r;
    logic [WORD_W-1:0]    shift_r;
    logic                 res_rd_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 msk_wr_r;
    logic [WORD_AW-1:0]   msk_addr_r;
    logic [WORD_W-1:0]    msk_do_r;
    logic [7:0]           max_val_r;
    logic [PIX_AW-1:0]    max_addr_r;
    logic [CNT_W-1:0]     obj_cnt_r;

    logic                 mask_bit_s;
    logic                 last_pix_s;
    logic                 word_end_s;
    logic                 start_ok_s;
    logic [WORD_W-1:0]    word_s;

    // Per-pixel decode of the current result-RAM word.
    always_comb begin
        mask_bit_s = (res_di != 8'd0) && (res_di >= thr_q_r);
        last_pix_s = (pix_cnt_r == PIX_AW'(NPIX - 1));
        word_end_s = &pix_cnt_r[BIT_AW-1:0];
        word_s     = {shift_r[WORD_W-2:0], mask_bit_s};
        start_ok_s = (state_r == IDLE) && start;
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SCAN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SCAN: begin
                if (last_pix_s) begin
                    state_next_s = FLUSH;
                end else begin
                    state_next_s = SCAN;
                end
            end
            FLUSH:   state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_rd_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            res_rd_r <= (state_next_s == SCAN);
            busy_r   <= (state_next_s != IDLE);
            done_r   <= (state_next_s == DONE);
        end
    end

    // Pixel address; returns to zero on leaving SCAN so res_addr idles at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_cnt_r <= {PIX_AW{1'b0}};
        end else if (state_r == SCAN) begin
            if (last_pix_s) begin
                pix_cnt_r <= {PIX_AW{1'b0}};
            end else begin
                pix_cnt_r <= pix_cnt_r + PIX_AW'(1);
            end
        end else begin
            pix_cnt_r <= {PIX_AW{1'b0}};
        end
    end

    // Statistics and mask shift register; results hold until the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thr_q_r    <= 8'd0;
            shift_r    <= {WORD_W{1'b0}};
            max_val_r  <= 8'd0;
            max_addr_r <= {PIX_AW{1'b0}};
            obj_cnt_r  <= {CNT_W{1'b0}};
        end else if (start_ok_s) begin
            thr_q_r    <= thr;
            shift_r    <= {WORD_W{1'b0}};
            max_val_r  <= 8'd0;
            max_addr_r <= {PIX_AW{1'b0}};
            obj_cnt_r  <= {CNT_W{1'b0}};
        end else if (state_r == SCAN) begin
            shift_r <= word_s;
            if (res_di != 8'd0) begin
                obj_cnt_r <= obj_cnt_r + CNT_W'(1);
            end
            // Strict compare keeps the earliest address on ties.
            if (res_di > max_val_r) begin
                max_val_r  <= res_di;
                max_addr_r <= pix_cnt_r;
            end
        end
    end

    // Mask word write, issued the cycle after a word's last pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msk_wr_r   <= 1'b0;
            msk_addr_r <= {WORD_AW{1'b0}};
            msk_do_r   <= {WORD_W{1'b0}};
        end else if ((state_r == SCAN) && word_end_s) begin
            msk_wr_r   <= 1'b1;
            msk_addr_r <= pix_cnt_r[PIX_AW-1:BIT_AW];
            msk_do_r   <= word_s;
        end else begin
            msk_wr_r   <= 1'b0;
        end
    end

    assign res_rd   = res_rd_r;
    assign res_addr = pix_cnt_r;
    assign msk_wr   = msk_wr_r;
    assign msk_addr = msk_addr_r;
    assign msk_do   = msk_do_r;
    assign max_val  = max_val_r;
    assign max_addr = max_addr_r;
    assign obj_cnt  = obj_cnt_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_dt_peak_scan.sv
// Bench for dt_peak_scan: directed and random maps checked against a
// whole-map reference computed with plain loops over the pixel array.
module tb_dt_peak_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  thr = 8'd0;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di;
    logic        msk_wr;
    logic [9:0]  msk_addr;
    logic [15:0] msk_do;
    logic [7:0]  max_val;
    logic [13:0] max_addr;
    logic [14:0] obj_cnt;
    logic        busy;
    logic        done;

    dt_peak_scan dut (
        .clk(clk), .reset(reset), .start(start), .thr(thr),
        .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
        .msk_wr(msk_wr), .msk_addr(msk_addr), .msk_do(msk_do),
        .max_val(max_val), .max_addr(max_addr), .obj_cnt(obj_cnt),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:16383];
    assign res_di = mem[res_addr];

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int adj_cnt = 0;
    int done_cnt = 0;
    int cyc = 0;
    logic prev_wr = 1'b0;
    logic [15:0] got [0:1023];
    logic [15:0] exp_word [0:1023];
    int exp_cnt, exp_max, exp_addr;

    // Mask-write and done monitor.
    always @(negedge clk) begin
        if (msk_wr === 1'b1) begin
            wr_cnt++;
            got[msk_addr] = msk_do;
            if (prev_wr === 1'b1) adj_cnt++;
        end
        if (done === 1'b1) done_cnt++;
        prev_wr = msk_wr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk);
        #1;
        wr_cnt = 0;
        adj_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 1024; i++) got[i] = 'x;
    endtask

    task automatic start_scan(input logic [7:0] t);
        clear_mon();
        @(negedge clk);
        thr = t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        thr = ~t;
        cyc = 1;
    endtask

    // Wait for done (bounded); optionally re-pulse start mid-scan.
    task automatic wait_done(input int dup_at, input logic [7:0] t2);
        while (done !== 1'b1 && cyc < 17000) begin
            if (cyc == dup_at) begin
                start = 1'b1;
                thr = t2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_latency", cyc, 16386);
    endtask

    task automatic model(input logic [7:0] t);
        exp_cnt = 0;
        exp_max = 0;
        exp_addr = 0;
        for (int w = 0; w < 1024; w++) exp_word[w] = 16'h0000;
        for (int a = 0; a < 16384; a++) begin
            int d;
            d = int'(mem[a]);
            if (d != 0) exp_cnt++;
            if (d > exp_max) begin
                exp_max = d;
                exp_addr = a;
            end
            if (d != 0 && d >= int'(t)) exp_word[a / 16][15 - (a % 16)] = 1'b1;
        end
    endtask

    task automatic verify(input string name, input logic [7:0] t);
        int nb;
        model(t);
        check({name, "_busy_in_done"}, busy, 1);
        check({name, "_max_val"}, max_val, exp_max);
        check({name, "_max_addr"}, max_addr, exp_addr);
        check({name, "_obj_cnt"}, obj_cnt, exp_cnt);
        @(negedge clk);
        #1;
        check({name, "_done_pulse"}, {busy, done}, 0);
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_wr_count"}, wr_cnt, 1024);
        check({name, "_wr_adjacent"}, adj_cnt, 0);
        check({name, "_idle_rd"}, {res_rd, res_addr}, 0);
        check({name, "_hold_max"}, {max_val, max_addr}, {exp_max[7:0], exp_addr[13:0]});
        check({name, "_hold_cnt"}, obj_cnt, exp_cnt);
        nb = 0;
        for (int w = 0; w < 1024; w++) if (got[w] !== exp_word[w]) nb++;
        check({name, "_mask_words_wrong"}, nb, 0);
    endtask

    initial begin
        #1;
        check("reset_a", {res_rd, res_addr, msk_wr, busy, done}, 0);
        check("reset_b", {msk_addr, msk_do}, 0);
        check("reset_c", {max_val, max_addr}, 0);
        check("reset_d", obj_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // All-zero map with thr=0: nonzero gating must keep every bit clear.
        for (int a = 0; a < 16384; a++) mem[a] = 8'd0;
        start_scan(8'd0);
        wait_done(-1, 8'd0);
        verify("zero", 8'd0);
        check("zero_word1023", got[1023], 16'h0000);

        // Single pixel at row 1, col 2.
        mem[130] = 8'd5;
        start_scan(8'd1);
        wait_done(-1, 8'd0);
        verify("single", 8'd1);
        check("single_word8", got[8], 16'h2000);
        check("single_addr", max_addr, 130);

        // Tied maxima plus sub-threshold row 0; second start must be ignored.
        for (int a = 0; a < 16384; a++) mem[a] = 8'd0;
        for (int a = 0; a < 128; a++) mem[a] = 8'd3;
        mem[200] = 8'd9;
        mem[7000] = 8'd9;
        start_scan(8'd4);
        wait_done(500, 8'd10);
        verify("ties", 8'd4);
        check("ties_word12", got[12], 16'h0080);
        check("ties_word0", got[0], 16'h0000);
        check("ties_first_addr", max_addr, 200);
        check("ties_cnt", obj_cnt, 130);

        // Random map rich in 255/254; scan aborted by reset at cycle 3000.
        for (int a = 0; a < 16384; a++) begin
            case ($urandom_range(0, 3))
                0:       mem[a] = 8'd0;
                1:       mem[a] = 8'd255;
                2:       mem[a] = 8'd254;
                default: mem[a] = 8'($urandom_range(0, 255));
            endcase
        end
        start_scan(8'd255);
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("midscan_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_ctrl", {res_rd, msk_wr, busy, done}, 0);
        check("abort_addr", res_addr, 0);
        check("abort_msk", {msk_addr, msk_do}, 0);
        check("abort_max", {max_val, max_addr}, 0);
        check("abort_cnt", obj_cnt, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", {busy, res_rd}, 0);

        // Fresh start on the same random map with thr=255.
        start_scan(8'd255);
        wait_done(-1, 8'd0);
        verify("rand255", 8'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dt_peak_scan.md
Name: dt_peak_scan

Overview:
- Post-processing stage directly downstream of the distance-transform engine.
- On the engine's done pulse, scans the 128x128 8-bit distance map in the result RAM once, in raster order.
- Produces a packed 1-bit threshold mask (1024 x 16-bit words, same packing as the input image ROM), the map maximum and its first address, and the object-pixel count.
- Outputs feed the downstream feature/skeleton logic.

Parameters:
- IMG_W, 128, image width in pixels (power of two)
- IMG_H, 128, image height in pixels
- WORD_W, 16, mask bits per packed word

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; tied to distance-transform done
- thr  input  8  mask threshold; sampled on accepted start
- res_rd  output  1  result-RAM read enable
- res_addr  output  14  result-RAM pixel address (row*128+col)
- res_di  input  8  result-RAM data; asynchronous read, valid in the same cycle as res_addr
- msk_wr  output  1  mask-RAM write strobe
- msk_addr  output  10  mask-RAM word address
- msk_do  output  16  packed mask word
- max_val  output  8  largest distance in map
- max_addr  output  14  address of first pixel holding max_val
- obj_cnt  output  15  number of nonzero pixels (0..16384)
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset are fixed: one clock (clk); reset is asynchronous and active-low, port named reset.
- Reset values: res_rd=0, res_addr=0, msk_wr=0, msk_addr=0, msk_do=0, max_val=0, max_addr=0, obj_cnt=0, busy=0, done=0, state=IDLE.
- States:
  - IDLE: waits for start. On start: thr_q<=thr, pix_cnt<=0, max/cnt/shift clear, next SCAN.
  - SCAN: res_rd=1, res_addr=pix_cnt. One pixel per cycle, no stalls. pix_cnt increments; at pix_cnt=16383, next FLUSH.
  - FLUSH: one cycle; commits the final mask word; next DONE.
  - DONE: done=1 for one cycle; next IDLE.
- busy=1 in SCAN, FLUSH, DONE.
- Pixel processing per SCAN cycle, with d=res_di:
  - mask bit = (d!=0) && (d>=thr_q), unsigned compare.
  - Bit shifts into a 16-bit shift register, MSB first: pixel col%16==0 lands in bit 15.
  - obj_cnt increments when d!=0. 15-bit counter; max 16384, no wrap.
  - If d>max_val (strictly greater), max_val<=d and max_addr<=pix_cnt. Ties keep the earliest address.
- Mask write:
  - When the pixel with pix_cnt[3:0]==15 is processed, the next cycle drives msk_wr=1 (registered), msk_addr=pix_cnt[13:4], msk_do=completed word.
  - For words 0..1022 this cycle is in SCAN. For word 1023 it is the FLUSH cycle.
  - msk_wr is high exactly 1024 times per scan, never two consecutive cycles.
  - msk_addr/msk_do hold their last values when msk_wr=0.
- Latency:
  - start at cycle T gives SCAN cycles T+1..T+16384, FLUSH at T+16385, done at T+16386.
  - max_val, max_addr and obj_cnt are final when done=1 and hold until the next accepted start.
- res_rd=0 and res_addr=0 outside SCAN.
- Boundary conditions:
  - start while busy: ignored; thr_q is not resampled.
  - start in the DONE cycle: ignored. Accepted only in IDLE.
  - All-zero map: max_val=0, max_addr=0, obj_cnt=0, all mask words 0.
  - thr=0: mask equals the nonzero map. thr=255: only pixels equal to 255 set.
  - Reset asserted mid-scan: all state and outputs return to reset values immediately. No partial done. A new start is required.
  - pix_cnt wraps 16383 to 0 only via the state exit; no extra read.

Test Plan:
- All-zero map, start, thr=1 -> 1024 writes of 0x0000 at msk_addr 0..1023; obj_cnt=0, max_val=0, max_addr=0; done exactly 16386 cycles after start.
- Single pixel value 5 at address 130 (row1,col2), thr=1 -> word 8 = 0x2000, all other words 0; max_val=5, max_addr=130, obj_cnt=1.
- Value 9 at addresses 200 and 7000, value 3 elsewhere in row 0, thr=4 -> max_val=9, max_addr=200 (tie keeps first); row-0 words 0x0000; word 12 = 0x0080; obj_cnt=130.
- Full map of 1s, thr=0 -> every word 0xFFFF; obj_cnt=16384; max_val=1, max_addr=0; msk_wr never high on adjacent cycles.
- Second start pulse at scan cycle 500 with a different thr -> ignored; results match a single-start run.
- Reset low at scan cycle 3000, then released, then start -> outputs zero after reset; no done pulse before the new scan; the new scan yields correct results.
